serial_adder: RTL and testbench

- Bit-serial unsigned adder. It is the additive counterpart of the team's half-subtractor datapath.
- Adds two WIDTH-bit operands one bit per clock, LSB first, using a single full-adder cell and a registered carry.
- Start/busy/done handshake. Used where area matters more than latency, and as the reference model for subtract/add pairing in the arithmetic library.

---
 rtl/serial_adder.sv | 123 ++++++++++++
 tb/tb_serial_adder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial unsigned adder. Two WIDTH-bit operands are added one bit per
//   clock, LSB first, through a single full-adder cell with a registered
//   carry. A start/busy/done handshake frames each operation. The result
//   registers hold the previous sum until the next operation completes.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (highest priority)
//   start      request, sampled only while idle
//   a, b       operands, captured on the accepted start edge
//   busy       high while bits are being added
//   done       one-cycle pulse, sum/carry_out valid
//   sum        registered (a+b) mod 2^WIDTH
//   carry_out  registered carry out of bit WIDTH-1
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             last;

  // Returns {carry, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    return {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

  assign {fa_c, fa_s} = full_add(shift_a[0], shift_b[0], carry);
  assign last         = (cnt == CW'(WIDTH - 1));

  // The accumulator shifts right with the new sum bit entering at the MSB,
  // so after WIDTH steps bit 0 of the result has reached position 0. The
  // shift form stays legal for WIDTH=1, where acc_next is just fa_s.
  assign acc_next = (acc >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, bit-serial add step and result update.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_a   <= '0;
      shift_b   <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_a <= a;
            shift_b <= b;
            acc     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
          end
        end
        RUN: begin
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          acc     <= acc_next;
          carry   <= fa_c;
          cnt     <= cnt + CW'(1);
          if (last) begin
            sum       <= acc_next;
            carry_out <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed bench for serial_adder with a WIDTH=8 and a WIDTH=1 instance.
//   Stimulus pushes expected {carry_out, sum} into a queue per instance; a
//   monitor pops and compares whenever that instance pulses done.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8, sum8;
  logic       a1, b1, sum1;
  logic       busy8, done8, co8;
  logic       busy1, done1, co1;

  int errors = 0;
  int checks = 0;
  int done_cnt8 = 0;
  int done_cnt1 = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] e8;
  logic [1:0] e1;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
  );

  serial_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      done_cnt8++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: got done with sum=%0d, no result expected", sum8);
      end else begin
        e8 = q8.pop_front();
        check("sum8", 32'(sum8), 32'(e8[7:0]));
        check("carry_out8", 32'(co8), 32'(e8[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      done_cnt1++;
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done1_unexpected: got done with sum=%0d, no result expected", sum1);
      end else begin
        e1 = q1.pop_front();
        check("sum1", 32'(sum1), 32'(e1[0]));
        check("carry_out1", 32'(co1), 32'(e1[1]));
      end
    end
  end

  // Waits (bounded) for done8; lat = clock edges from start edge to done edge.
  task automatic wait_done8(output int lat, output int bc);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    bc   = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (busy8) bc++;
      if (done8) begin
        lat  = n - 1;
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done8_timeout: got no done within 40 cycles, required done");
    end
  endtask

  task automatic wait_done1(output int lat, output int bc);
    bit seen;
    seen = 1'b0;
    lat  = -1;
    bc   = 0;
    for (int n = 1; n <= 10 && !seen; n++) begin
      @(negedge clk);
      if (busy1) bc++;
      if (done1) begin
        lat  = n - 1;
        seen = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done1_timeout: got no done within 10 cycles, required done");
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] es, input logic eco);
    int lat, bc;
    @(posedge clk); #1;
    a8 = a; b8 = b; start8 = 1'b1;
    q8.push_back({eco, es});
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(lat, bc);
    check("latency8", 32'(lat), 32'd8);
    check("busy_cycles8", 32'(bc), 32'd8);
    @(negedge clk);
    check("done8_one_cycle", 32'(done8), 32'd0);
  endtask

  task automatic run1(input logic a, input logic b, input logic es, input logic eco);
    int lat, bc;
    @(posedge clk); #1;
    a1 = a; b1 = b; start1 = 1'b1;
    q1.push_back({eco, es});
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done1(lat, bc);
    check("latency1", 32'(lat), 32'd1);
    check("busy_cycles1", 32'(bc), 32'd1);
    @(negedge clk);
    check("done1_one_cycle", 32'(done1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bc, dc;
    bit restarted;
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy8", 32'(busy8), 32'd0);
    check("reset_done8", 32'(done8), 32'd0);
    check("reset_sum8", 32'(sum8), 32'd0);
    check("reset_co8", 32'(co8), 32'd0);
    check("reset_busy1", 32'(busy1), 32'd0);
    check("reset_sum1", 32'(sum1), 32'd0);
    check("reset_co1", 32'(co1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic add and carry out
    run8(8'd3, 8'd5, 8'd8, 1'b0);
    run8(8'd200, 8'd100, 8'd44, 1'b1);
    run8(8'd255, 8'd1, 8'd0, 1'b1);

    // Ignored start during RUN and DONE; operands captured only at start
    @(posedge clk); #1;
    a8 = 8'd10; b8 = 8'd20; start8 = 1'b1;
    q8.push_back({1'b0, 8'd30});
    @(posedge clk); #1;
    start8 = 1'b0;
    dc = done_cnt8;
    repeat (2) @(posedge clk);
    #1;
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    wait_done8(lat, bc);
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd5;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("ignored_start_busy", 32'(busy8), 32'd0);
    check("ignored_start_done_count", 32'(done_cnt8 - dc), 32'd1);

    // Continuous start: result holds through the next run
    @(posedge clk); #1;
    a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
    q8.push_back({1'b0, 8'd16});
    @(posedge clk); #1;
    a8 = 8'd20; b8 = 8'd22;
    q8.push_back({1'b0, 8'd42});
    wait_done8(lat, bc);
    check("b2b_latency", 32'(lat), 32'd8);
    restarted = 1'b0;
    for (int n = 0; n < 5 && !restarted; n++) begin
      @(negedge clk);
      if (busy8) restarted = 1'b1;
    end
    start8 = 1'b0;
    check("b2b_restarted", 32'(restarted), 32'd1);
    check("b2b_sum_hold_early", 32'(sum8), 32'd16);
    repeat (4) @(negedge clk);
    check("b2b_sum_hold_mid", 32'(sum8), 32'd16);
    wait_done8(lat, bc);
    @(negedge clk);

    // Reset in the middle of a run
    @(posedge clk); #1;
    a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    dc = done_cnt8;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_sum", 32'(sum8), 32'd0);
    check("abort_co", 32'(co8), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt8 - dc), 32'd0);
    check("abort_idle", 32'(busy8), 32'd0);
    run8(8'd1, 8'd2, 8'd3, 1'b0);

    // WIDTH=1 exhaustive
    run1(1'b0, 1'b0, 1'b0, 1'b0);
    run1(1'b0, 1'b1, 1'b1, 1'b0);
    run1(1'b1, 1'b0, 1'b1, 1'b0);
    run1(1'b1, 1'b1, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("queue8_drained", 32'(q8.size()), 32'd0);
    check("queue1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
